// File: rtl/debounced_input_pio_if.sv
// Slave bus bundle for the debounced input PIO.
// Word-addressed register port plus level interrupt.
interface debounced_input_pio_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, read, write, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, read, write, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/debounced_input_pio.sv
// N-channel synchronised, debounced input port with
// edge capture and a maskable level interrupt.
module debounced_input_pio #(
  parameter int               WIDTH           = 10,
  parameter int               DEBOUNCE_CYCLES = 500000,
  parameter int               CNT_W           = 20,
  parameter int               EDGE_MODE       = 0,
  parameter logic [WIDTH-1:0] RESET_LEVEL     = '0
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset_n,
  input  logic [WIDTH-1:0]     in_export,
  debounced_input_pio_if.slave bus
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1, sync2;
  logic [WIDTH-1:0] deb, deb_q;
  logic [WIDTH-1:0] edgecap, irqmask;
  logic [WIDTH-1:0] rise, fall, edge_sel;
  logic [WIDTH-1:0] clr;
  logic [31:0]      rd_mux;
  logic             wr_en, rd_en;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sync1 <= RESET_LEVEL;
      sync2 <= RESET_LEVEL;
    end else begin
      sync1 <= in_export;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic             d_r;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
        cnt <= '0;
        d_r <= RESET_LEVEL[i];
      end else if (sync2[i] == d_r) begin
        cnt <= '0;
      end else if (cnt == TERM) begin
        cnt <= '0;
        d_r <= sync2[i];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end

    assign deb[i] = d_r;
  end

  assign wr_en = bus.chipselect & bus.write;
  assign rd_en = bus.chipselect & bus.read;
  assign rise  = deb & ~deb_q;
  assign fall  = ~deb & deb_q;

  always_comb begin
    edge_sel = rise | fall;
    if (EDGE_MODE == 0) edge_sel = rise;
    if (EDGE_MODE == 1) edge_sel = fall;
  end

  always_comb begin
    clr = '0;
    if (wr_en && bus.address == 2'd3)
      clr = bus.writedata[WIDTH-1:0];
  end

  always_comb begin
    rd_mux = '0;
    case (bus.address)
      2'd0:    rd_mux = 32'(deb);
      2'd1:    rd_mux = 32'(sync2);
      2'd2:    rd_mux = 32'(irqmask);
      default: rd_mux = 32'(edgecap);
    endcase
  end

  // A fresh edge beats a same-cycle clear.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      deb_q        <= RESET_LEVEL;
      edgecap      <= '0;
      irqmask      <= '0;
      bus.readdata <= '0;
      bus.irq      <= 1'b0;
    end else begin
      deb_q   <= deb;
      edgecap <= (edgecap & ~clr) | edge_sel;
      bus.irq <= |(edgecap & irqmask);
      if (wr_en && bus.address == 2'd2)
        irqmask <= bus.writedata[WIDTH-1:0];
      if (rd_en)
        bus.readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_debounced_input_pio.sv
// Randomised bench for debounced_input_pio against a
// window-based behavioural model, three configurations.
module tb_debounced_input_pio;

  localparam int W  = 4;
  localparam int D  = 4;
  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [W-1:0] pins = '1;
  logic [1:0]  addr = '0;
  logic        cs = 1'b0, rd = 1'b0, wr = 1'b0;
  logic [31:0] wdata = '0;
  logic        chk_en = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  debounced_input_pio_if b0 ();
  debounced_input_pio_if b1 ();
  debounced_input_pio_if b2 ();

  assign b0.address = addr; assign b0.chipselect = cs;
  assign b0.read = rd; assign b0.write = wr;
  assign b0.writedata = wdata;
  assign b1.address = addr; assign b1.chipselect = cs;
  assign b1.read = rd; assign b1.write = wr;
  assign b1.writedata = wdata;
  assign b2.address = addr; assign b2.chipselect = cs;
  assign b2.read = rd; assign b2.write = wr;
  assign b2.writedata = wdata;

  debounced_input_pio #(
    .WIDTH(W), .DEBOUNCE_CYCLES(D), .CNT_W(3),
    .EDGE_MODE(0), .RESET_LEVEL(4'h0)
  ) u0 (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .in_export(pins), .bus(b0)
  );

  debounced_input_pio #(
    .WIDTH(W), .DEBOUNCE_CYCLES(D), .CNT_W(3),
    .EDGE_MODE(1), .RESET_LEVEL(4'hF)
  ) u1 (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .in_export(pins), .bus(b1)
  );

  debounced_input_pio #(
    .WIDTH(W), .DEBOUNCE_CYCLES(D), .CNT_W(3),
    .EDGE_MODE(2), .RESET_LEVEL(4'h0)
  ) u2 (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .in_export(pins), .bus(b2)
  );

  logic [31:0] obs_rd [NI];
  logic        obs_irq [NI];
  assign obs_rd[0] = b0.readdata; assign obs_irq[0] = b0.irq;
  assign obs_rd[1] = b1.readdata; assign obs_irq[1] = b1.irq;
  assign obs_rd[2] = b2.readdata; assign obs_irq[2] = b2.irq;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: the debounced bit flips once the last D
  // synchronised samples all disagree with it.
  int          mode [NI] = '{0, 1, 2};
  logic [W-1:0] rlev [NI] = '{4'h0, 4'hF, 4'h0};
  logic [W-1:0] m_s1 [NI], m_sync [NI], m_deb [NI];
  logic [W-1:0] m_pend [NI], m_ec [NI], m_mask [NI];
  logic [W-1:0] win [NI][D];
  logic [31:0]  m_rd [NI];
  logic         m_irq [NI];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NI; k++) begin
        m_s1[k] = rlev[k]; m_sync[k] = rlev[k];
        m_deb[k] = rlev[k]; m_pend[k] = '0;
        m_ec[k] = '0; m_mask[k] = '0;
        m_rd[k] = '0; m_irq[k] = 1'b0;
        for (int j = 0; j < D; j++) win[k][j] = rlev[k];
      end
    end else begin
      for (int k = 0; k < NI; k++) begin
        logic [W-1:0] nd, up, dn, clr;
        m_irq[k] = |(m_ec[k] & m_mask[k]);
        if (cs && rd) begin
          case (addr)
            2'd0: m_rd[k] = 32'(m_deb[k]);
            2'd1: m_rd[k] = 32'(m_sync[k]);
            2'd2: m_rd[k] = 32'(m_mask[k]);
            default: m_rd[k] = 32'(m_ec[k]);
          endcase
        end
        clr = (cs && wr && addr == 2'd3) ? wdata[W-1:0] : '0;
        m_ec[k] = (m_ec[k] & ~clr) | m_pend[k];
        for (int j = 0; j < D - 1; j++) win[k][j] = win[k][j+1];
        win[k][D-1] = m_sync[k];
        nd = m_deb[k];
        for (int b = 0; b < W; b++) begin
          bit all_diff;
          all_diff = 1'b1;
          for (int j = 0; j < D; j++)
            if (win[k][j][b] == m_deb[k][b]) all_diff = 1'b0;
          if (all_diff) nd[b] = ~m_deb[k][b];
        end
        up = nd & ~m_deb[k];
        dn = ~nd & m_deb[k];
        m_pend[k] = (mode[k] == 0) ? up :
                    (mode[k] == 1) ? dn : (up | dn);
        m_deb[k] = nd;
        if (cs && wr && addr == 2'd2) m_mask[k] = wdata[W-1:0];
        m_sync[k] = m_s1[k];
        m_s1[k] = pins;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < NI; k++) begin
        check($sformatf("rd%0d", k), obs_rd[k], m_rd[k]);
        check($sformatf("irq%0d", k), 32'(obs_irq[k]),
              32'(m_irq[k]));
      end
    end
  end

  task automatic idle(input int n);
    cs = 1'b0; rd = 1'b0; wr = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    cs = 1'b1; rd = 1'b0; wr = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic bus_rd(input logic [1:0] a);
    cs = 1'b1; rd = 1'b1; wr = 1'b0; addr = a;
    @(negedge clk);
    cs = 1'b0; rd = 1'b0;
  endtask

  int hold = 0;

  initial begin
    pins = 4'hF;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    cs = 1'b1; rd = 1'b1; addr = 2'd0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("dat_e6", b0.readdata, 32'h0);
    @(negedge clk);
    check("dat_e7", b0.readdata, 32'hF);
    idle(3);
    bus_rd(2'd3);
    check("ec_rst0", b0.readdata, 32'hF);
    check("ec_rst1", b1.readdata, 32'h0);
    check("ec_rst2", b2.readdata, 32'hF);
    check("irq_rst", 32'(b0.irq), 32'h0);

    bus_wr(2'd3, 32'hF);
    bus_wr(2'd2, 32'hFFFF_FFF2);
    idle(2);
    bus_rd(2'd2);
    check("mask_rd", b0.readdata, 32'h2);
    pins[1] = 1'b0;
    idle(12);
    check("irq_fall0", 32'(b0.irq), 32'h0);
    pins[1] = 1'b1;
    idle(12);
    check("irq_rise0", 32'(b0.irq), 32'h1);
    bus_wr(2'd3, 32'h2);
    idle(1);
    check("irq_clr0", 32'(b0.irq), 32'h0);
    bus_rd(2'd3);
    check("ec_clr0", b0.readdata, 32'h0);

    pins[2] = 1'b0;
    idle(12);
    bus_wr(2'd3, 32'hF);
    idle(2);
    pins[2] = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    bus_wr(2'd3, 32'h4);
    bus_rd(2'd3);
    check("set_win", b0.readdata, 32'h4);
    check("set_irq", 32'(b0.irq), 32'h0);

    bus_wr(2'd0, 32'h0);
    bus_rd(2'd0);
    check("data_ro", b0.readdata, 32'hF);
    pins = 4'h0;
    idle(2);
    bus_rd(2'd1);
    check("raw_2cyc", b0.readdata, 32'h0);
    idle(10);

    for (int c = 0; c < 3000; c++) begin
      int op;
      if (hold == 0) begin
        pins = W'($urandom);
        hold = $urandom_range(1, 8);
      end
      hold--;
      op = $urandom_range(0, 99);
      addr = 2'($urandom);
      wdata = $urandom;
      cs = (op < 90);
      rd = (op < 60) || (op >= 95);
      wr = (op >= 60);
      if (c == 1500) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    idle(2);
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/debounced_input_pio.md
Name: debounced_input_pio

Overview:
- Parametrised memory-mapped input port for the board's keys and switches.
- Replaces plain input PIOs with N-channel synchronisation, per-channel debouncing, configurable edge capture and a maskable interrupt.
- Sits on the system interconnect as a slave.
- One instance per input bank: for example, WIDTH=2 for keys and WIDTH=10 for switches.

Parameters:
- WIDTH, 10, number of input channels (1..32).
- DEBOUNCE_CYCLES, 500000, number of consecutive stable cycles required before a channel's debounced value changes (10 ms at 50 MHz); minimum 2.
- CNT_W, 20, width of each channel's debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- EDGE_MODE, 0, which transitions set edge capture: 0 rising, 1 falling, 2 both.
- RESET_LEVEL, 0, per-bit reset value of the debounced register (WIDTH bits); keys use all-ones.

Ports:
- clk_clk  input  1  system clock.
- reset_reset_n  input  1  asynchronous active-low reset.
- in_export  input  WIDTH  raw asynchronous inputs from pins.
- address  input  2  register word address.
- chipselect  input  1  slave select.
- read  input  1  read strobe.
- write  input  1  write strobe.
- writedata  input  32  write data.
- readdata  output  32  read data, registered.
- irq  output  1  level interrupt.

Behaviour:
- Clocking and reset:
  - Single clock domain; reset_reset_n is asynchronous and active-low.
  - Reset values: sync flops = RESET_LEVEL; debounced = RESET_LEVEL; counters = 0; irqmask = 0; edgecap = 0; readdata = 0; irq = 0.
- Synchroniser:
  - Two-flop synchroniser per bit produces sync[i].
- Debounce, per channel:
  - If sync[i] == debounced[i], the counter clears to 0.
  - Otherwise the counter increments.
  - When the counter equals DEBOUNCE_CYCLES-1 while still differing, debounced[i] <= sync[i] and the counter clears.
  - Any glitch returning to the debounced value before terminal count restarts the count from 0.
  - Latency from a pin change to debounced change: 2 sync cycles + DEBOUNCE_CYCLES cycles.
- Edge detect:
  - A rising edge is debounced[i] going 0->1 in a given cycle; a falling edge is 1->0.
  - The selected edge types (per EDGE_MODE) set edgecap[i] in the next cycle.
- Register map (word addresses):
  - 0 DATA: read-only; bits[WIDTH-1:0] = debounced; upper bits 0; writes ignored.
  - 1 RAW: read-only; sync value, for diagnostics.
  - 2 IRQMASK: read/write; bits[WIDTH-1:0]; upper write bits ignored.
  - 3 EDGECAP: read; writing 1 to a bit clears it, writing 0 has no effect.
- Bus timing:
  - An access occurs only when chipselect=1.
  - Read: readdata is valid one cycle after read&chipselect; readdata holds its last value otherwise.
  - Write: takes effect at the clock edge where write&chipselect is asserted.
  - read and write are never asserted together; if they are, the write is performed and readdata is still updated.
- Simultaneous events:
  - A new edge on bit i in the same cycle as a write-1-to-clear of bit i: set wins and edgecap[i] = 1.
  - Edges on multiple channels in the same cycle are all captured.
- Interrupt:
  - irq = OR over i of (edgecap[i] & irqmask[i]), registered, so 1 cycle after edgecap/irqmask change.
  - irq stays asserted until software clears the bits or masks them.
- Reset mid-operation:
  - All state returns to reset values immediately (asynchronous).
  - After release, channels whose input differs from RESET_LEVEL debounce normally and produce an edge if selected.

Test Plan (DEBOUNCE_CYCLES=4, WIDTH=4, EDGE_MODE=0, RESET_LEVEL=0 unless noted):
- Reset: in=4'hF held, reset_n released -> DATA=0 until cycle 2+4 after release; then DATA=4'hF, EDGECAP=4'hF, irq=0 (mask 0).
- Bounce rejection: in[0] toggles 1,0,1 every 2 cycles, then holds 1 -> DATA[0] changes only 6 cycles after the final stable 1; exactly one edgecap[0] set.
- Interrupt: write IRQMASK=4'b0010; debounced in[1] rises -> irq=1 one cycle after edgecap[1]; write EDGECAP=4'b0010 -> irq=0 next cycle; EDGECAP reads 0.
- Set-over-clear: write EDGECAP=4'b0100 in the same cycle debounced[2] rises -> EDGECAP reads 4'b0100, irq state unchanged.
- EDGE_MODE=1 with RESET_LEVEL=4'hF (keys): in[0] 1->0 sets edgecap[0]; 0->1 does not. EDGE_MODE=2: both transitions set it.
- Register access: reads of addr 0..3 return data one cycle after read; a write to DATA leaves it unchanged; upper bits [31:WIDTH] read 0; RAW reflects a pin change after 2 cycles.
